// File: rtl/audio_power_sequencer_if.sv
// Control bundle between the board-level glue and audio_power_sequencer.
//   master : board side, drives raw ready flags, sample tick, button and switches,
//            and observes the sequenced outputs.
//   slave  : the sequencer itself.
// Signal summary:
//   ready_i[NUM_READY]  subsystem ready flags (async)
//   sample_tick_i       one-cycle pulse per audio sample
//   button_i            raw button, active-low (async)
//   sw_i[NUM_SW]        raw switches (async)
//   switches_o          debounced switches
//   button_stb_o        short-press release strobe
//   long_stb_o          long-press threshold strobe
//   engine_srst_o       audio engine synchronous reset
//   relay_o             1 = effect path engaged
//   dac_mute_o          1 = DAC muted
//   bypass_o            current bypass selection
//   ready_o             sequencer in RUN
//   state_o             FSM state for LEDs/debug
interface audio_power_sequencer_if #(
   parameter int NUM_READY = 2,
   parameter int NUM_SW    = 3
);
   logic [NUM_READY-1:0] ready_i;
   logic                 sample_tick_i;
   logic                 button_i;
   logic [NUM_SW-1:0]    sw_i;
   logic [NUM_SW-1:0]    switches_o;
   logic                 button_stb_o;
   logic                 long_stb_o;
   logic                 engine_srst_o;
   logic                 relay_o;
   logic                 dac_mute_o;
   logic                 bypass_o;
   logic                 ready_o;
   logic [2:0]           state_o;

   modport master (
      output ready_i, sample_tick_i, button_i, sw_i,
      input  switches_o, button_stb_o, long_stb_o, engine_srst_o,
             relay_o, dac_mute_o, bypass_o, ready_o, state_o
   );

   modport slave (
      input  ready_i, sample_tick_i, button_i, sw_i,
      output switches_o, button_stb_o, long_stb_o, engine_srst_o,
             relay_o, dac_mute_o, bypass_o, ready_o, state_o
   );
endinterface

// File: rtl/audio_power_sequencer.sv
// Audio power sequencer: debounces switches and the button, sequences the
// audio engine reset, relay and DAC mute from the subsystem ready flags, and
// toggles bypass click-free by muting around every relay change.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   bus      audio_power_sequencer_if.slave (see interface file for signals)

// One raw asynchronous input: 2-FF synchroniser followed by a debouncer.
// q_o follows the synchronised input only after CYCLES consecutive clocks
// of disagreement; any agreeing clock restarts the count.
module aps_debounce #(
   parameter int   CYCLES  = 1200,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);
   localparam int CW = $clog2(CYCLES + 1);

   logic [1:0]    sync;
   logic [CW-1:0] cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         sync <= {2{RST_VAL}};
         cnt  <= '0;
         q_o  <= RST_VAL;
      end else begin
         sync <= {sync[0], d_i};
         if (sync[1] == q_o) begin
            cnt <= '0;
         end else if (cnt == CW'(CYCLES - 1)) begin
            q_o <= sync[1];
            cnt <= '0;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end
endmodule

module audio_power_sequencer #(
   parameter int NUM_READY        = 2,
   parameter int NUM_SW           = 3,
   parameter int DEBOUNCE_CYCLES  = 1200,
   parameter int SETTLE_TICKS     = 4800,
   parameter int MUTE_TICKS       = 480,
   parameter int LONG_PRESS_TICKS = 48000
) (
   input logic                      clk_i,
   input logic                      rst_n_i,
   audio_power_sequencer_if.slave   bus
);
   typedef enum logic [2:0] {
      WAIT_READY = 3'd0,
      SETTLE     = 3'd1,
      RUN        = 3'd2,
      PRE_MUTE   = 3'd3,
      SWITCH     = 3'd4,
      POST_MUTE  = 3'd5
   } state_t;

   localparam int TMAX = (SETTLE_TICKS > MUTE_TICKS) ? SETTLE_TICKS : MUTE_TICKS;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(LONG_PRESS_TICKS + 1);

   // ---------------- input conditioning ----------------
   logic [NUM_SW-1:0]    sw_db;
   logic                 btn_db_n;
   logic                 btn_pressed;
   logic [NUM_READY-1:0] rdy_s1, rdy_s2;
   logic                 all_ready;

   for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
      aps_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b0)) u_db (
         .clk_i   (clk_i),
         .rst_n_i (rst_n_i),
         .d_i     (bus.sw_i[i]),
         .q_o     (sw_db[i])
      );
   end

   // Button idles high; resetting its path to 1 avoids a phantom press at reset.
   aps_debounce #(.CYCLES(DEBOUNCE_CYCLES), .RST_VAL(1'b1)) u_btn (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .d_i     (bus.button_i),
      .q_o     (btn_db_n)
   );
   assign btn_pressed = ~btn_db_n;

   // Ready flags are level signals, only synchronised (no debounce).
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         rdy_s1 <= '0;
         rdy_s2 <= '0;
      end else begin
         rdy_s1 <= bus.ready_i;
         rdy_s2 <= rdy_s1;
      end
   end
   assign all_ready = &rdy_s2;

   // ---------------- press timer ----------------
   // press_cnt saturates at the threshold, so press_cnt == LONG_PRESS_TICKS
   // on release means the long strobe already fired for this press.
   logic [PW-1:0] press_cnt;
   logic          btn_q;
   logic          button_stb, long_stb;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         press_cnt  <= '0;
         btn_q      <= 1'b0;
         button_stb <= 1'b0;
         long_stb   <= 1'b0;
      end else begin
         btn_q      <= btn_pressed;
         button_stb <= 1'b0;
         long_stb   <= 1'b0;
         if (btn_pressed) begin
            if (bus.sample_tick_i && press_cnt != PW'(LONG_PRESS_TICKS)) begin
               press_cnt <= press_cnt + PW'(1);
               if (press_cnt == PW'(LONG_PRESS_TICKS - 1))
                  long_stb <= 1'b1;
            end
         end else begin
            press_cnt <= '0;
            if (btn_q && press_cnt != PW'(LONG_PRESS_TICKS))
               button_stb <= 1'b1;
         end
      end
   end

   // ---------------- sequencer FSM ----------------
   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          srst, mute, relay, bypass, run;
   logic          settle_done, mute_done;

   // A zero settle time skips the tick wait entirely.
   assign settle_done = (SETTLE_TICKS == 0) ||
                        (bus.sample_tick_i && tick_cnt == TW'(SETTLE_TICKS - 1));
   assign mute_done   = bus.sample_tick_i && tick_cnt == TW'(MUTE_TICKS - 1);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state    <= WAIT_READY;
         tick_cnt <= '0;
         srst     <= 1'b1;
         mute     <= 1'b1;
         relay    <= 1'b0;
         bypass   <= 1'b0;
         run      <= 1'b0;
      end else begin
         if (bus.sample_tick_i)
            tick_cnt <= tick_cnt + TW'(1);
         // Losing any ready flag wins over everything, including a press.
         if (state != WAIT_READY && !all_ready) begin
            state    <= WAIT_READY;
            tick_cnt <= '0;
            srst     <= 1'b1;
            mute     <= 1'b1;
            relay    <= 1'b0;
            run      <= 1'b0;
         end else begin
            case (state)
               WAIT_READY: if (all_ready) begin
                  state    <= SETTLE;
                  tick_cnt <= '0;
                  srst     <= 1'b0;
                  relay    <= ~bypass;
               end
               SETTLE: if (settle_done) begin
                  state    <= RUN;
                  tick_cnt <= '0;
                  mute     <= 1'b0;
                  run      <= 1'b1;
               end
               RUN: if (button_stb) begin
                  state    <= PRE_MUTE;
                  tick_cnt <= '0;
                  mute     <= 1'b1;
                  run      <= 1'b0;
               end
               PRE_MUTE: if (mute_done) begin
                  state    <= SWITCH;
                  tick_cnt <= '0;
                  bypass   <= ~bypass;
                  relay    <= bypass;   // = !(new bypass)
               end
               SWITCH: begin
                  state    <= POST_MUTE;
                  tick_cnt <= '0;
               end
               POST_MUTE: if (mute_done) begin
                  state    <= RUN;
                  tick_cnt <= '0;
                  mute     <= 1'b0;
                  run      <= 1'b1;
               end
               default: begin
                  state    <= WAIT_READY;
                  tick_cnt <= '0;
                  srst     <= 1'b1;
                  mute     <= 1'b1;
                  relay    <= 1'b0;
                  run      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.switches_o    = sw_db;
   assign bus.button_stb_o  = button_stb;
   assign bus.long_stb_o    = long_stb;
   assign bus.engine_srst_o = srst;
   assign bus.relay_o       = relay;
   assign bus.dac_mute_o    = mute;
   assign bus.bypass_o      = bypass;
   assign bus.ready_o       = run;
   assign bus.state_o       = state;
endmodule

// File: tb/tb_audio_power_sequencer.sv
// Directed bench for audio_power_sequencer with small timing parameters.
// Strobes are checked through a scoreboard queue; state/output checks are
// immediate assertions at each step.
module tb_audio_power_sequencer;
   localparam int NR = 2, NS = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   audio_power_sequencer_if #(.NUM_READY(NR), .NUM_SW(NS)) bus ();

   audio_power_sequencer #(
      .NUM_READY(NR), .NUM_SW(NS), .DEBOUNCE_CYCLES(4), .SETTLE_TICKS(8),
      .MUTE_TICKS(2), .LONG_PRESS_TICKS(16)
   ) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int checks = 0;
   int errors = 0;
   int tick_seen = 0;
   logic [1:0] sb[$];   // 1 = short strobe, 2 = long strobe
   logic prev_relay = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] get(input int sel);
      case (sel)
         0: return 32'(bus.state_o);
         1: return 32'(bus.engine_srst_o);
         2: return 32'(bus.dac_mute_o);
         3: return 32'(bus.relay_o);
         4: return 32'(bus.bypass_o);
         5: return 32'(bus.ready_o);
         default: return 32'(bus.switches_o);
      endcase
   endfunction

   // Waits (bounded) until the selected output equals val; n = negedges waited.
   task automatic wait_val(input string tag, input int sel, input logic [31:0] val,
                           input int budget, output int n);
      n = 0;
      while (n < budget && get(sel) !== val) begin
         @(negedge clk);
         n++;
      end
      chk(tag, get(sel), val);
   endtask

   task automatic press(input int clocks);
      bus.button_i = 1'b0;
      repeat (clocks) @(negedge clk);
      bus.button_i = 1'b1;
   endtask

   // Sample tick: one clock high out of every four.
   initial begin
      bus.sample_tick_i = 1'b0;
      forever begin
         repeat (3) @(posedge clk);
         #1 bus.sample_tick_i = 1'b1;
         @(posedge clk);
         #1 bus.sample_tick_i = 1'b0;
      end
   end

   always @(posedge clk) if (bus.sample_tick_i) tick_seen <= tick_seen + 1;

   // Strobe scoreboard.
   always @(negedge clk) begin
      logic [1:0] e;
      if (bus.button_stb_o || bus.long_stb_o) begin
         e = (sb.size() != 0) ? sb.pop_front() : 2'd0;
         chk("sb_strobe", {30'd0, bus.long_stb_o, bus.button_stb_o}, 32'(e));
      end
   end

   // The relay may only move while the DAC is muted.
   always @(negedge clk) begin
      if (bus.relay_o !== prev_relay) chk("relay_unmuted", 32'(bus.dac_mute_o), 32'd1);
      prev_relay <= bus.relay_o;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n, t0;
      logic bad;
      bus.ready_i  = '0;
      bus.button_i = 1'b1;
      bus.sw_i     = '0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_state", get(0), 0);
      chk("rst_srst",  get(1), 1);
      chk("rst_mute",  get(2), 1);
      chk("rst_relay", get(3), 0);
      chk("rst_byp",   get(4), 0);
      chk("rst_ready", get(5), 0);
      chk("rst_sw",    get(6), 0);
      chk("rst_stb",   32'({bus.long_stb_o, bus.button_stb_o}), 0);
      rst_n = 1'b1;

      // Partial ready holds the sequencer in WAIT_READY
      bus.ready_i = 2'b01;
      bad = 1'b0;
      repeat (100) begin
         @(negedge clk);
         if (bus.state_o !== 3'd0 || bus.dac_mute_o !== 1'b1 || bus.relay_o !== 1'b0 ||
             bus.engine_srst_o !== 1'b1) bad = 1'b1;
      end
      chk("partial_ready", 32'(bad), 0);

      // Power-up
      bus.ready_i = 2'b11;
      wait_val("pwr_srst", 1, 0, 10, n);
      chk("pwr_lat", n, 3);
      t0 = tick_seen;
      chk("pwr_relay", get(3), 1);
      chk("pwr_state", get(0), 1);
      chk("pwr_mute",  get(2), 1);
      wait_val("pwr_unmute", 2, 0, 60, n);
      chk("settle_ticks", tick_seen - t0, 8);
      chk("pwr_ready", get(5), 1);
      chk("pwr_run",   get(0), 2);

      // Bypass toggle with a short press
      sb.push_back(2'd1);
      press(24);
      wait_val("tg_mute", 2, 1, 60, n);
      t0 = tick_seen;
      chk("tg_pre_state", get(0), 3);
      chk("tg_pre_relay", get(3), 1);
      chk("tg_pre_ready", get(5), 0);
      wait_val("tg_byp", 4, 1, 40, n);
      chk("tg_pre_ticks", tick_seen - t0, 2);
      t0 = tick_seen;
      chk("tg_sw_state", get(0), 4);
      chk("tg_sw_relay", get(3), 0);
      chk("tg_sw_mute",  get(2), 1);
      wait_val("tg_unmute", 2, 0, 40, n);
      chk("tg_post_ticks", tick_seen - t0, 2);
      chk("tg_run", get(0), 2);
      chk("tg_relay", get(3), 0);

      // Switch debounce: 3-clock glitches never pass, stable level does
      bad = 1'b0;
      repeat (4) begin
         bus.sw_i = 3'b010;
         repeat (3) begin @(negedge clk); if (bus.switches_o !== 3'b000) bad = 1'b1; end
         bus.sw_i = 3'b000;
         repeat (3) begin @(negedge clk); if (bus.switches_o !== 3'b000) bad = 1'b1; end
      end
      repeat (6) begin @(negedge clk); if (bus.switches_o !== 3'b000) bad = 1'b1; end
      chk("sw_glitch", 32'(bad), 0);
      bus.sw_i = 3'b010;
      wait_val("sw_stable", 6, 32'b010, 20, n);
      chk("sw_lat", n, 6);

      // Long press: long strobe only, no bypass change
      sb.push_back(2'd2);
      press(80);
      repeat (30) @(negedge clk);
      chk("lp_sb_empty", sb.size(), 0);
      chk("lp_byp",   get(4), 1);
      chk("lp_state", get(0), 2);

      // Ready loss during POST_MUTE with a simultaneous press
      sb.push_back(2'd1);
      press(24);
      wait_val("rl_post", 0, 5, 100, n);
      bus.ready_i  = 2'b10;
      sb.push_back(2'd1);
      bus.button_i = 1'b0;
      wait_val("rl_wait", 0, 0, 10, n);
      chk("rl_lat",   n, 3);
      chk("rl_mute",  get(2), 1);
      chk("rl_relay", get(3), 0);
      chk("rl_srst",  get(1), 1);
      chk("rl_ready", get(5), 0);
      chk("rl_byp",   get(4), 0);
      repeat (16) @(negedge clk);
      bus.button_i = 1'b1;
      repeat (20) @(negedge clk);
      chk("rl_hold_state", get(0), 0);
      chk("rl_hold_byp",   get(4), 0);

      // Restore ready: full settle, bypass retained
      bus.ready_i = 2'b11;
      wait_val("rs_srst", 1, 0, 10, n);
      t0 = tick_seen;
      chk("rs_relay", get(3), 1);
      wait_val("rs_unmute", 2, 0, 60, n);
      chk("rs_ticks", tick_seen - t0, 8);
      chk("rs_byp",   get(4), 0);

      // Toggle to bypass=1, drop all ready, bypass held, relay follows on settle
      sb.push_back(2'd1);
      press(24);
      wait_val("t2_byp", 4, 1, 100, n);
      wait_val("t2_run", 0, 2, 40, n);
      bus.ready_i = 2'b00;
      wait_val("d2_wait", 0, 0, 10, n);
      chk("d2_byp", get(4), 1);
      bus.ready_i = 2'b11;
      wait_val("r2_srst", 1, 0, 10, n);
      chk("r2_relay", get(3), 0);
      repeat (10) @(negedge clk);
      chk("r2_settle", get(0), 1);

      // Async reset mid-settle
      #2 rst_n = 1'b0;
      #1;
      chk("ar_state", get(0), 0);
      chk("ar_srst",  get(1), 1);
      chk("ar_mute",  get(2), 1);
      chk("ar_byp",   get(4), 0);
      chk("ar_sw",    get(6), 0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      chk("sb_final_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/audio_power_sequencer.md
Name: audio_power_sequencer

Overview:
Parametrised successor to the fixed ready-to-relay/mute wiring at board top level. It debounces the switch and button inputs, sequences audio engine reset, relay and DAC mute from N subsystem-ready flags, and performs click-free bypass toggling by muting around relay changes. It sits between design_sybsystems and audio_engine and drives relay_o, dac_mute_o and the status LEDs.

Parameters:
NUM_READY, 2, number of subsystem ready flags (PLL lock, SDRAM init, ...)
NUM_SW, 3, number of raw switch inputs
DEBOUNCE_CYCLES, 1200, consecutive stable clocks required before a debounced input changes (>=1)
SETTLE_TICKS, 4800, sample ticks between engine reset release and unmute (0 allowed)
MUTE_TICKS, 480, sample ticks of mute before and after a relay change (>=1)
LONG_PRESS_TICKS, 48000, sample ticks a button must be held to count as a long press

Ports:
clk_i  in  1  system clock
rst_n_i  in  1  asynchronous active-low reset
ready_i  in  NUM_READY  subsystem ready flags, asynchronous to clk_i
sample_tick_i  in  1  one-cycle pulse per audio sample
button_i  in  1  raw button, active-low, asynchronous
sw_i  in  NUM_SW  raw switches, asynchronous
switches_o  out  NUM_SW  debounced switches
button_stb_o  out  1  one-cycle pulse on release of a short press
long_stb_o  out  1  one-cycle pulse when the hold reaches LONG_PRESS_TICKS
engine_srst_o  out  1  synchronous reset to audio_engine
relay_o  out  1  1 = effect path engaged
dac_mute_o  out  1  1 = DAC muted
bypass_o  out  1  current bypass selection
ready_o  out  1  sequencer in RUN
state_o  out  3  FSM state encoding for LEDs/debug

Behaviour:
- Reset (rst_n_i low, async): state WAIT_READY; engine_srst_o=1, dac_mute_o=1, relay_o=0, bypass_o=0, ready_o=0, strobes=0, switches_o=0, all counters 0.
- All async inputs pass through 2-FF synchronisers. Debouncer per input: the output takes the synchronised value after DEBOUNCE_CYCLES consecutive clocks differing from the current output; any glitch restarts the count. Button path is inverted (pressed = 1) after debounce.
- Press timer counts sample ticks while the debounced button is pressed, saturating at LONG_PRESS_TICKS. long_stb_o pulses once on the cycle it reaches the threshold. button_stb_o pulses on release only if the threshold was never reached. Both are registered and depend on sample_tick_i and the button only.
- all_ready = AND of synchronised ready_i.
- FSM (state_o encoding): WAIT_READY=0, SETTLE=1, RUN=2, PRE_MUTE=3, SWITCH=4, POST_MUTE=5.
- WAIT_READY: outputs at reset values except bypass_o, which is held. When all_ready, go to SETTLE next cycle.
- SETTLE: engine_srst_o=0; relay_o=!bypass_o; mute held. Count sample ticks. When the count reaches SETTLE_TICKS, go to RUN; with SETTLE_TICKS=0, go to RUN on the next cycle.
- RUN: dac_mute_o=0, ready_o=1. A button_stb_o pulse moves to PRE_MUTE. long_stb_o has no FSM effect.
- PRE_MUTE: dac_mute_o=1 immediately (registered on entry). Count MUTE_TICKS sample ticks, then go to SWITCH.
- SWITCH: one clock. bypass_o toggles; relay_o=!new bypass. Go to POST_MUTE.
- POST_MUTE: mute held. Count MUTE_TICKS ticks, then go to RUN with dac_mute_o=0.
- Presses during PRE_MUTE, SWITCH or POST_MUTE are not queued. The strobes still emit.
- Priority: all_ready low in any state other than WAIT_READY forces WAIT_READY on the next edge. dac_mute_o=1, relay_o=0, engine_srst_o=1, ready_o=0 all take effect at that same edge. This overrides a button event in the same cycle.
- Sample tick counters reset on every state entry. If sample_tick_i stops, the FSM waits indefinitely and dac_mute_o/relay_o are held.
- Invariant: relay_o never changes while dac_mute_o=0.

Test Plan:
Use DEBOUNCE_CYCLES=4, SETTLE_TICKS=8, MUTE_TICKS=2, LONG_PRESS_TICKS=16, and a sample tick every 4 clocks.
- Power-up: ready_i 00->11 -> engine_srst_o falls ~3 clk later (sync + transition); relay_o=1; dac_mute_o falls after 8 ticks; ready_o=1; state_o=2.
- Partial ready: ready_i=01 held for 100 clk -> state_o=0, mute=1, relay=0, engine_srst_o=1 throughout.
- Bypass toggle: a press of 6 ticks in RUN, then release -> one button_stb_o pulse. Mute rises, then after 2 ticks bypass_o=1 and relay_o=0, then after 2 more ticks mute=0. Relay edge occurs only while muted.
- Debounce: sw_i[1] glitches of 3 clk repeated -> switches_o unchanged; stable 4+ clk -> switches_o[1] follows.
- Long press: hold 20 ticks -> long_stb_o pulses once at tick 16, no button_stb_o on release, bypass_o unchanged.
- Ready loss: drop ready_i[0] during POST_MUTE with a simultaneous press -> mute=1, relay=0, engine_srst_o=1 within sync latency plus 1 clk. Restore ready -> full SETTLE with bypass_o retained. Async rst_n_i mid-SETTLE -> all outputs at reset values immediately.
